muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit.
- Consumes the two operand values read from register_file (reg1/reg2) plus the destination register index.
- Returns a result, destination index and write strobe that drive register_file's reg_write/rd/write inputs.
- Fixed-latency, single-outstanding-operation handshake (start/busy/done) so the control path can stall deterministically.

---
 rtl/muldiv_unit.sv | 257 +++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide execution unit. One operation in flight at
//   a time; every op (special cases included) takes the same number of cycles,
//   so the control path can stall deterministically on busy.
//
//   Sequencing: IDLE --start--> CALC (WIDTH iterations) --> FIX (sign fix-up,
//   result registered, done pulse) --> IDLE.
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset, aborts any operation in flight
//   start    : request, sampled only while idle
//   op       : RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   rs1_val  : operand A (multiplicand / dividend)
//   rs2_val  : operand B (multiplier / divisor)
//   rd_in    : destination register index, latched with start
//   busy     : operation in progress
//   done     : one-cycle pulse, result valid
//   result   : final value, held until the next completion
//   rd_out   : destination index of the last accepted operation
//   write    : register-file write enable (done and rd_out != 0)
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out,
  output logic             write
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Sequencing state
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;

  // Datapath: hi/lo hold {product} for multiply and {remainder, quotient}
  // for divide; m holds the multiplicand or divisor magnitude.
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q, m_d;

  // Sign and special-case flags captured at start
  logic             a_neg_q, a_neg_d;
  logic             diff_neg_q, diff_neg_d;
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;

  // Outputs
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  // Operand decode at start
  logic             a_signed, b_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Per-iteration and fix-up datapath
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_val;

  always_comb begin
    a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed && rs1_val[WIDTH-1];
    b_neg    = b_signed && rs2_val[WIDTH-1];
    // The most-negative value maps onto itself, which is the correct
    // unsigned magnitude.
    a_mag    = a_neg ? -rs1_val : rs1_val;
    b_mag    = b_neg ? -rs2_val : rs2_val;
  end

  always_comb begin
    // Shift-add step: add multiplicand when the multiplier LSB is set,
    // then shift the whole {carry, hi, lo} right by one.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    // Restoring step: bring the next dividend bit into the remainder and
    // try subtracting the divisor; a set MSB means the trial went negative.
    // The partial remainder stays below the divisor, so the W+1 bit window
    // never overflows (a zero divisor always accepts and just shifts).
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, m_q};

    prod      = {hi_q, lo_q};
    prod_fix  = diff_neg_q ? -prod : prod;
    quo_fix   = diff_neg_q ? -lo_q : lo_q;
    // With a zero divisor the remainder path ends holding |rs1|, so the
    // dividend-sign fix-up reproduces rs1 exactly.
    rem_fix   = a_neg_q ? -hi_q : hi_q;

    fix_val = prod_fix[WIDTH-1:0];
    case (op_q)
      OP_MUL:             fix_val = prod_fix[WIDTH-1:0];
      OP_DIV, OP_DIVU: begin
        if (div0_q)       fix_val = {WIDTH{1'b1}};
        else if (ovf_q)   fix_val = MOST_NEG;
        else              fix_val = quo_fix;
      end
      OP_REM, 3'b111: begin
        if (div0_q)       fix_val = rem_fix;
        else if (ovf_q)   fix_val = {WIDTH{1'b0}};
        else              fix_val = rem_fix;
      end
      default:            fix_val = prod_fix[2*WIDTH-1:WIDTH];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    rd_d       = rd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    m_d        = m_q;
    a_neg_d    = a_neg_q;
    diff_neg_d = diff_neg_q;
    div0_d     = div0_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CALC;
          cnt_d      = '0;
          busy_d     = 1'b1;
          op_d       = op;
          rd_d       = rd_in;
          a_neg_d    = a_neg;
          diff_neg_d = a_neg ^ b_neg;
          div0_d     = (rs2_val == '0);
          ovf_d      = (op == OP_DIV || op == OP_REM) &&
                       (rs1_val == MOST_NEG) && (rs2_val == {WIDTH{1'b1}});
          hi_d       = '0;
          if (op[2]) begin
            lo_d = a_mag;   // dividend shifts out of lo, quotient shifts in
            m_d  = b_mag;
          end else begin
            lo_d = b_mag;   // multiplier shifts out of lo, product shifts in
            m_d  = a_mag;
          end
        end
      end

      S_CALC: begin
        if (op_q[2]) begin
          if (div_trial[WIDTH]) begin
            hi_d = div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end else begin
            hi_d = div_trial[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      S_FIX: begin
        result_d = fix_val;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      m_q        <= '0;
      a_neg_q    <= 1'b0;
      diff_neg_q <= 1'b0;
      div0_q     <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      m_q        <= m_d;
      a_neg_q    <= a_neg_d;
      diff_neg_q <= diff_neg_d;
      div0_q     <= div0_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_q;
  assign write  = done_q && (rd_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed vectors with hand-computed results. The driver pushes the
//   expected response (value, rd, write, completion cycle) into a queue when
//   it issues an operation; an independent monitor pops and compares on every
//   done pulse, and also checks the busy run length preceding it.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = 33;   // edges from the start edge to the done edge

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b0;
  logic [W-1:0] rs1_val = '0;
  logic [W-1:0] rs2_val = '0;
  logic [4:0]   rd_in = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [4:0]   rd_out;
  logic         write;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rd_out  (rd_out),
    .write   (write)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   rd;
    logic         wr;
    int           cyc;
    string        name;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [4:0]   rd;
    string        name;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, well away from the active edge.
  initial begin
    exp_t e;
    int   busy_run;
    busy_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_run = 0;
      end else if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done result=%0h rd_out=%0d cyc=%0d", result, rd_out, cyc);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_result"}, result, e.res);
          chk({e.name, "_rd_out"}, rd_out, e.rd);
          chk({e.name, "_write"}, write, e.wr);
          chk({e.name, "_done_cycle"}, cyc, e.cyc);
          chk({e.name, "_busy_len"}, busy_run, LAT);
          chk({e.name, "_busy_at_done"}, busy, 1'b0);
          $display("txn %s result=%08h rd_out=%0d write=%0b cyc=%0d",
                   e.name, result, rd_out, write, cyc);
        end
        busy_run = 0;
      end else if (busy) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
    end
  end

  // Called at posedge+1; the next rising edge is the start edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] rd, input logic [W-1:0] exp_res, input string nm);
    exp_t e;
    start   = 1'b1;
    op      = o;
    rs1_val = a;
    rs2_val = b;
    rd_in   = rd;
    e.res   = exp_res;
    e.rd    = rd;
    e.wr    = (rd != 5'd0);
    e.cyc   = cyc + 1 + LAT;
    e.name  = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start   = 1'b0;
    // Scramble the inputs after the start edge; they must not matter.
    op      = 3'($urandom);
    rs1_val = $urandom;
    rs2_val = $urandom;
    rd_in   = 5'($urandom);
  endtask

  // Leaves the caller at posedge+1 inside the done cycle.
  task automatic wait_done(input string nm);
    total++;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(posedge clk);
      #1;
      if (done) return;
    end
    bad++;
    $display("FAIL %s_timeout no done within %0d cycles", nm, 2 * LAT);
  endtask

  task automatic add_vec(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r, input logic [4:0] rd, input string nm);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.r = r; v.rd = rd; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    add_vec(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5'd1,  "mulh_minmin");
    add_vec(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd2,  "mulhu_max");
    add_vec(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  "mulhsu_m1");
    add_vec(DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 5'd4,  "div_neg7_2");
    add_vec(REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 5'd5,  "rem_neg7_2");
    add_vec(DIVU,   32'd100,       32'd7,         32'd14,        5'd6,  "divu_100_7");
    add_vec(REMU,   32'd100,       32'd7,         32'd2,         5'd7,  "remu_100_7");
    add_vec(DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 5'd8,  "divu_by0");
    add_vec(REMU,   32'd5,         32'd0,         32'd5,         5'd9,  "remu_by0");
    add_vec(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd10, "div_ovf");
    add_vec(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         5'd11, "rem_ovf");
    add_vec(DIV,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 5'd12, "div_neg_by0");
    add_vec(REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 5'd13, "rem_neg_by0");
    add_vec(MUL,    32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 5'd14, "mul_lowbits");

    // Reset and idle outputs
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_busy",   busy,   1'b0);
    chk("rst_done",   done,   1'b0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd_out", rd_out, 5'd0);
    chk("rst_write",  write,  1'b0);

    // Basic MUL, then verify single-cycle done and held outputs
    issue(MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, "mul_7_m3");
    wait_done("mul_7_m3");
    @(posedge clk);
    #1;
    chk("done_one_cycle", done,   1'b0);
    chk("write_drops",    write,  1'b0);
    chk("result_hold",    result, 32'hFFFF_FFEB);
    chk("rd_out_hold",    rd_out, 5'd5);

    // Directed table, each op issued in the previous op's done cycle
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].r, vecs[i].name);
      wait_done(vecs[i].name);
    end
    @(posedge clk);
    #1;

    // start while busy is ignored
    issue(MUL, 32'd3, 32'd4, 5'd9, 32'd12, "mul_ignore_start");
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; op = DIVU; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("mul_ignore_start");
    @(posedge clk);
    #1;

    // Reset mid-operation aborts without a done
    issue(MUL, 32'd3, 32'd4, 5'd6, 32'd12, "mul_abort");
    repeat (8) @(posedge clk);
    #1;
    start = 1'b1; op = MUL; rs1_val = 32'd5; rs2_val = 32'd6; rd_in = 5'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy",   busy,   1'b0);
    chk("abort_done",   done,   1'b0);
    chk("abort_result", result, 32'd0);
    chk("abort_rd_out", rd_out, 5'd0);
    chk("abort_write",  write,  1'b0);
    repeat (2 * LAT) @(posedge clk);
    #1;
    chk("abort_still_idle", busy, 1'b0);
    chk("abort_result_idle", result, 32'd0);
    issue(MUL, 32'd3, 32'd4, 5'd7, 32'd12, "mul_fresh");
    wait_done("mul_fresh");
    @(posedge clk);
    #1;

    // Back-to-back with rd=0 on the first op
    issue(MUL, 32'd2, 32'd3, 5'd0, 32'd6, "b2b_mul_rd0");
    wait_done("b2b_mul_rd0");
    issue(DIVU, 32'd9, 32'd3, 5'd4, 32'd3, "b2b_divu");
    wait_done("b2b_divu");
    repeat (3) @(posedge clk);
    #1;

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
